// File: rtl/arith_chain_pkg.sv
// Shared constants and helpers for the arith chain and its result FIFO.
package arith_chain_pkg;

  localparam int unsigned DATA_WIDTH_OUT       = 10;
  localparam int unsigned ARITH_FIFO_DEPTH_DEF = 4;

  // Pointer width for a power-of-two depth of at least 2.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/arith_fifo_mem.sv
// Result FIFO storage: one synchronous write port, one asynchronous read port.
module arith_fifo_mem
  import arith_chain_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_OUT,
  parameter int unsigned DEPTH      = ARITH_FIFO_DEPTH_DEF,
  localparam int unsigned AW        = ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/arith_result_fifo.sv
// First-word-fall-through FIFO buffering arith chain results; drops on full.
// Define ARITH_FIFO_DROP_CNT_EN to build in the saturating 8-bit drop counter.
module arith_result_fifo
  import arith_chain_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_OUT,
  parameter int unsigned DEPTH      = ARITH_FIFO_DEPTH_DEF,
  localparam int unsigned AW        = ptr_width(DEPTH),
  localparam int unsigned CW        = AW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic [7:0]            drop_count
);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          drop;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign valid_out = !empty;
  assign pop       = valid_out && ready_in;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push      = valid_in && (!full || pop);
  assign drop      = valid_in && full && !ready_in;

  arith_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (data_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef ARITH_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign drop_count = drop_cnt;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_arith_result_fifo.sv
// Self-checking bench for arith_result_fifo against a queue-based reference model.
module tb_arith_result_fifo;

  localparam int unsigned DW    = 10;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic          valid_in = 1'b0;
  logic          ready_in = 1'b0;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic [2:0]    count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic [7:0]    drop_count;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] q[$];
  bit            m_ovf;
  int            m_drops;

  arith_result_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  function automatic int exp_dc();
`ifdef ARITH_FIFO_DROP_CNT_EN
    return (m_drops > 255) ? 255 : m_drops;
`else
    return 0;
`endif
  endfunction

  // One clock: apply inputs, advance the model by the FIFO's rules, sample #1 after the edge.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit r);
    bit p_pop, p_push;
    valid_in = v;
    data_in  = d;
    ready_in = r;
    p_pop  = (q.size() != 0) && r;
    p_push = v && ((q.size() < DEPTH) || p_pop);
    @(posedge clk);
    #1;
    if (p_pop) void'(q.pop_front());
    if (p_push) q.push_back(d);
    if (v && !p_push) begin
      m_ovf = 1'b1;
      m_drops++;
    end
  endtask

  task automatic apply_reset();
    valid_in = 1'b0;
    ready_in = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    m_ovf   = 1'b0;
    m_drops = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b exp 1", empty); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got %b exp 0", full); end
    tests++; if (valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", valid_out); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    tests++; if (drop_count !== 8'd0) begin fails++; $display("FAIL reset_dc got %0d exp 0", drop_count); end
  endtask

  task automatic test_single();
    apply_reset();
    step(1, 10'h012, 0);
    tests++; if (valid_out !== 1'b1) begin fails++; $display("FAIL single_valid got %b exp 1", valid_out); end
    tests++; if (data_out !== 10'h012) begin fails++; $display("FAIL single_data got %h exp 012", data_out); end
    tests++; if (count !== 3'd1) begin fails++; $display("FAIL single_count got %0d exp 1", count); end
    step(0, '0, 1);
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL single_empty got %b exp 1", empty); end
    step(0, '0, 1);
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL single_ready_empty got %0d exp 0", count); end
  endtask

  task automatic test_burst_full();
    apply_reset();
    for (int i = 1; i <= 4; i++) step(1, DW'(i), 0);
    tests++; if (full !== 1'b1) begin fails++; $display("FAIL burst_full got %b exp 1", full); end
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL burst_count got %0d exp 4", count); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL burst_ovf_pre got %b exp 0", overflow); end
    step(1, 10'd5, 0);
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL burst_ovf got %b exp 1", overflow); end
    tests++; if (int'(drop_count) !== exp_dc()) begin fails++; $display("FAIL burst_dc got %0d exp %0d", drop_count, exp_dc()); end
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL burst_drop_count got %0d exp 4", count); end
    for (int i = 1; i <= 4; i++) begin
      tests++; if (valid_out !== 1'b1 || data_out !== DW'(i)) begin
        fails++; $display("FAIL burst_drain%0d got v=%b d=%0d exp v=1 d=%0d", i, valid_out, data_out, i);
      end
      step(0, '0, 1);
    end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL burst_empty got %b exp 1", empty); end
  endtask

  task automatic test_full_pushpop();
    logic [DW-1:0] exp_seq [4];
    exp_seq = '{10'd2, 10'd3, 10'd4, 10'd9};
    apply_reset();
    for (int i = 1; i <= 4; i++) step(1, DW'(i), 0);
    step(1, 10'd9, 1);
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL fpp_count got %0d exp 4", count); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL fpp_ovf got %b exp 0", overflow); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (valid_out !== 1'b1 || data_out !== exp_seq[i]) begin
        fails++; $display("FAIL fpp_drain%0d got v=%b d=%0d exp v=1 d=%0d", i, valid_out, data_out, exp_seq[i]);
      end
      step(0, '0, 1);
    end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL fpp_empty got %b exp 1", empty); end
  endtask

  task automatic test_stream_wrap();
    apply_reset();
    for (int v = 4; v <= 13; v++) begin
      step(1, DW'(v), 1);
      tests++; if (valid_out !== 1'b1 || data_out !== DW'(v) || count !== 3'd1) begin
        fails++; $display("FAIL stream%0d got v=%b d=%0d c=%0d exp v=1 d=%0d c=1", v, valid_out, data_out, count, v);
      end
    end
    step(0, '0, 1);
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL stream_empty got %b exp 1", empty); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 4; i++) step(1, DW'(20 + i), 0);
    step(1, 10'd99, 0);
    step(0, '0, 1);
    tests++; if (count !== 3'd3 || overflow !== 1'b1) begin
      fails++; $display("FAIL mid_pre got c=%0d o=%b exp c=3 o=1", count, overflow);
    end
    ready_in = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    tests++; if (count !== 3'd0 || valid_out !== 1'b0 || overflow !== 1'b0) begin
      fails++; $display("FAIL mid_async got c=%0d v=%b o=%b exp c=0 v=0 o=0", count, valid_out, overflow);
    end
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    m_drops = 0;
    step(1, 10'h3FF, 0);
    tests++; if (valid_out !== 1'b1 || data_out !== 10'h3FF || count !== 3'd1) begin
      fails++; $display("FAIL mid_push got v=%b d=%h c=%0d exp v=1 d=3ff c=1", valid_out, data_out, count);
    end
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int i = 0; i < 4; i++) step(1, DW'(i), 0);
    for (int i = 0; i < 300; i++) begin
      step(1, DW'(i), 0);
      if (i == 254) begin
        tests++; if (int'(drop_count) !== exp_dc()) begin fails++; $display("FAIL sat_255 got %0d exp %0d", drop_count, exp_dc()); end
      end
    end
    tests++; if (int'(drop_count) !== exp_dc()) begin fails++; $display("FAIL sat_300 got %0d exp %0d", drop_count, exp_dc()); end
    tests++; if (overflow !== 1'b1 || count !== 3'd4) begin
      fails++; $display("FAIL sat_state got o=%b c=%0d exp o=1 c=4", overflow, count);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 3) != 0), DW'($urandom), ($urandom_range(0, 2) == 0));
      tests++; if (int'(count) !== q.size() || empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) begin
        fails++; $display("FAIL rand_count cyc%0d got c=%0d e=%b f=%b exp c=%0d", n, count, empty, full, q.size());
      end
      tests++; if (valid_out !== (q.size() != 0) || (q.size() != 0 && data_out !== q[0])) begin
        fails++; $display("FAIL rand_head cyc%0d got v=%b d=%h exp v=%b d=%h", n, valid_out, data_out,
                          (q.size() != 0), (q.size() != 0) ? q[0] : 10'h0);
      end
      tests++; if (overflow !== m_ovf || int'(drop_count) !== exp_dc()) begin
        fails++; $display("FAIL rand_drop cyc%0d got o=%b dc=%0d exp o=%b dc=%0d", n, overflow, drop_count, m_ovf, exp_dc());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_full();
    test_full_pushpop();
    test_stream_wrap();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/arith_result_fifo.md
ARITH_RESULT_FIFO -- requirements
Module: arith_result_fifo

Interface
REQ-001 DATA_WIDTH, default 10, SHALL set the entry width; it matches the arith chain output width.
REQ-002 DEPTH, default 4, SHALL set the number of entries; it SHALL be a power of two and at least 2.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 data_in  input  DATA_WIDTH  SHALL carry the result word from the upstream arith chain (its data_out).
REQ-006 valid_in  input  1  SHALL qualify data_in (the upstream valid_out); it has no backpressure.
REQ-007 data_out  output  DATA_WIDTH  SHALL present the head entry.
REQ-008 valid_out  output  1  SHALL be high when data_out holds a valid head entry.
REQ-009 ready_in  input  1  SHALL be the downstream consumer's ready signal.
REQ-010 count  output  log2(DEPTH)+1  SHALL give the current occupancy, from 0 to DEPTH.
REQ-011 full / empty  output  1 each  SHALL flag count==DEPTH and count==0.
REQ-012 overflow  output  1  SHALL be a sticky flag that a word was dropped.
REQ-013 drop_count  output  8  SHALL give the number of dropped words (see Configuration).

Function
REQ-014 Push condition SHALL be valid_in && (!full || pop).
REQ-015 Pop condition SHALL be valid_out && ready_in.
REQ-016 Output SHALL be first-word-fall-through: valid_out = !empty, and data_out = mem[rd_ptr] with no extra register.
REQ-017 Latency SHALL be one cycle: a word pushed at edge N appears on data_out/valid_out after edge N, if the FIFO was empty.
REQ-018 Words SHALL emerge in push order with no duplication or loss, except for words dropped under REQ-021.
REQ-019 wr_ptr and rd_ptr SHALL wrap from DEPTH-1 to 0.
REQ-020 Simultaneous push and pop SHALL leave count unchanged, including when full (the pop frees the slot) and when count==1.
REQ-021 valid_in && full && !ready_in SHALL drop data_in, set overflow, and leave mem, pointers and count unchanged.
REQ-022 Push while empty SHALL NOT pop in the same cycle, because valid_out is low that cycle.
REQ-023 ready_in while empty SHALL have no effect.
REQ-024 data_out SHALL be don't-care while valid_out is low; the bench SHALL NOT check it then.

Reset
REQ-025 Asserting reset SHALL immediately clear wr_ptr, rd_ptr, count, overflow and drop_count, giving empty=1, full=0, valid_out=0.
REQ-026 Reset asserted mid-stream SHALL discard all stored words; mem contents need no reset.
REQ-027 The first push SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-028 Macro ARITH_FIFO_DROP_CNT_EN defined SHALL compile in an 8-bit drop counter that increments on each REQ-021 drop, saturates at 255, and drives drop_count.
REQ-029 Macro ARITH_FIFO_DROP_CNT_EN undefined SHALL tie drop_count to 0 and add no counter logic; the port list SHALL be identical in both builds.

Structure
REQ-030 Shared package arith_chain_pkg SHALL hold DATA_WIDTH_OUT (10), ARITH_FIFO_DEPTH_DEF (4) and the pointer-width helper function.
REQ-031 Storage SHALL be one sub-module, arith_fifo_mem: a DEPTH x DATA_WIDTH array with one synchronous write port and one asynchronous read port.
REQ-032 Pointer, count and flag logic SHALL reside in arith_result_fifo.

Verification
REQ-033 Single word: push 0x012 with ready_in=0 -> the cycle after, valid_out=1, data_out=0x012, count=1; raise ready_in -> empty=1 next cycle.
REQ-034 Burst to full: push 1,2,3,4 back-to-back with ready_in=0 -> full=1, count=4; push 5 -> overflow=1, drop_count=1 (macro on) or 0 (macro off); drain reads 1,2,3,4.
REQ-035 Full with simultaneous push/pop: from full holding 1..4, push 9 with ready_in=1 -> count stays 4, overflow stays 0, drain reads 2,3,4,9.
REQ-036 Wrap-around streaming: with ready_in=1, push values 4..13 back-to-back -> output 4..13 in order at one word per cycle, count never above 1.
REQ-037 Reset mid-operation: with count=3, assert reset asynchronously between edges -> count=0, valid_out=0, overflow=0 immediately; a subsequent push of 0x3FF is read back correctly.
REQ-038 Saturation (macro on): 300 drops while full -> drop_count=255.
